// File: rtl/ctu_dbgbus_src_if.sv
// ============================================================================
// Module  : ctu_dbgbus_src_if
// Brief   : Debug-sample input and debug-bus segment output of one source.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ctu_dbgbus_src_if;
  logic        dbg_vld;
  logic [39:0] dbg_data;
  logic        peer_busy;
  logic [40:0] dbgbus_out;

  // master: the bus source that drives a segment; slave: the unit/repeater side.
  modport master (input dbg_vld, input dbg_data, input peer_busy, output dbgbus_out);
  modport slave  (output dbg_vld, output dbg_data, output peer_busy, input dbgbus_out);
endinterface

`default_nettype wire

// File: rtl/ctu_dbgbus_src.sv
// ============================================================================
// Module  : ctu_dbgbus_src
// Brief   : Decimating debug-sample capture with a FIFO feeding a shared,
//           priority-arbitrated 41-bit debug bus segment.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ctu_dbgbus_src #(
  parameter int DEPTH   = 4,
  parameter int HIPRI   = 0,
  parameter int DECIM_W = 4
) (
  input  wire logic                     rclk,
  input  wire logic                     arst_l,
  input  wire logic                     dbg_en,
  input  wire logic [DECIM_W-1:0]       decim,
  input  wire logic                     ovf_clr,
  ctu_dbgbus_src_if.master              bus,
  output logic                          ovf,
  output logic [$clog2(DEPTH):0]        fifo_cnt,
  output logic                          dbg_active
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_CNT_FULL = (c_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_active;
  logic [DECIM_W-1:0]   r_dcnt;
  logic [c_AW-1:0]      r_wptr;
  logic [c_AW-1:0]      r_rptr;
  logic [c_AW:0]        r_cnt;
  logic [39:0]          r_mem [DEPTH];
  logic [40:0]          r_out;
  logic                 r_ovf;

  logic                 w_peer_ok;
  logic                 w_qual;
  logic                 w_capture;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [c_AW:0]        w_cnt_nxt;

  // The priority segment owns bit 40 of the repeater and never yields.
  generate
    if (HIPRI != 0) begin : g_hipri
      assign w_peer_ok = 1'b1;
    end else begin : g_lopri
      assign w_peer_ok = ~bus.peer_busy;
    end
  endgenerate

  assign w_qual    = (r_state == ST_RUN) & bus.dbg_vld;
  assign w_capture = w_qual & (r_dcnt == '0);
  assign w_full    = (r_cnt == c_CNT_FULL);
  // Pop looks only at stored entries, so a capture never bypasses the FIFO.
  assign w_pop     = (r_cnt != '0) & w_peer_ok;
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + (c_AW + 1)'(1);
      2'b01:   w_cnt_nxt = r_cnt - (c_AW + 1)'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state  <= ST_IDLE;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (dbg_en) begin
            r_state  <= ST_RUN;
            r_active <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!dbg_en) begin
            if (r_cnt != '0) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state  <= ST_IDLE;
              r_active <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (dbg_en) begin
            r_state <= ST_RUN;
          end else if (w_cnt_nxt == '0) begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  // Held at zero outside RUN so the first qualified sample in RUN is captured.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_dcnt <= '0;
    end else if (r_state != ST_RUN) begin
      r_dcnt <= '0;
    end else if (w_qual) begin
      if (r_dcnt == '0) begin
        r_dcnt <= decim;
      end else begin
        r_dcnt <= r_dcnt - DECIM_W'(1);
      end
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      r_cnt <= w_cnt_nxt;
      r_out <= w_pop ? {1'b1, r_mem[r_rptr]} : 41'b0;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Storage is not reset; the pointers define which entries are live.
  always_ff @(posedge rclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.dbg_data;
    end
  end

  assign bus.dbgbus_out = r_out;
  assign ovf            = r_ovf;
  assign fifo_cnt       = r_cnt;
  assign dbg_active     = r_active;

endmodule

`default_nettype wire

// File: tb/tb_ctu_dbgbus_src.sv
// ============================================================================
// Module  : tb_ctu_dbgbus_src
// Brief   : Directed, table-driven bench for ctu_dbgbus_src.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctu_dbgbus_src;

  typedef struct {
    logic        en;
    logic        vld;
    logic [39:0] data;
    logic [3:0]  decim;
    logic        pb;
    logic        clr;
    logic [40:0] exp_out;
    logic [2:0]  exp_cnt;
    logic        exp_ovf;
    logic        exp_act;
  } vec_t;

  logic       clk;
  logic       arst_l;
  logic       en, clr;
  logic [3:0] decim;
  logic       ovf;
  logic [2:0] cnt;
  logic       act;
  logic       en_h, clr_h;
  logic [3:0] decim_h;
  logic       ovf_h;
  logic [2:0] cnt_h;
  logic       act_h;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[$];

  ctu_dbgbus_src_if bus_m ();
  ctu_dbgbus_src_if bus_h ();

  ctu_dbgbus_src #(.DEPTH(4), .HIPRI(0), .DECIM_W(4)) u_dut (
    .rclk(clk), .arst_l(arst_l), .dbg_en(en), .decim(decim), .ovf_clr(clr),
    .bus(bus_m), .ovf(ovf), .fifo_cnt(cnt), .dbg_active(act)
  );

  ctu_dbgbus_src #(.DEPTH(4), .HIPRI(1), .DECIM_W(4)) u_hip (
    .rclk(clk), .arst_l(arst_l), .dbg_en(en_h), .decim(decim_h), .ovf_clr(clr_h),
    .bus(bus_h), .ovf(ovf_h), .fifo_cnt(cnt_h), .dbg_active(act_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [40:0] lnch(input logic [39:0] d);
    return {1'b1, d};
  endfunction

  function automatic void add(input logic e, input logic v, input logic [39:0] d,
                              input logic [3:0] dc, input logic p, input logic c,
                              input logic [40:0] eo, input logic [2:0] ec,
                              input logic ev, input logic ea);
    vec_t t;
    t.en = e; t.vld = v; t.data = d; t.decim = dc; t.pb = p; t.clr = c;
    t.exp_out = eo; t.exp_cnt = ec; t.exp_ovf = ev; t.exp_act = ea;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [40:0] a, input logic [40:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic e, input logic v, input logic [39:0] d, input logic p);
    en = e; bus_m.dbg_vld = v; bus_m.dbg_data = d; bus_m.peer_busy = p;
  endtask

  initial begin
    arst_l = 1'b0;
    en = 0; clr = 0; decim = 0;
    drive_m(0, 0, 40'h0, 0);
    en_h = 0; clr_h = 0; decim_h = 0;
    bus_h.dbg_vld = 0; bus_h.dbg_data = '0; bus_h.peer_busy = 0;

    // en vld data decim pb clr | out cnt ovf act
    add(1, 0, 40'h0,            0, 0, 0, 41'h0,                    0, 0, 1);
    add(1, 1, 40'hA5_0000_0001, 0, 0, 0, 41'h0,                    1, 0, 1);
    add(1, 0, 40'h0,            0, 0, 0, lnch(40'hA5_0000_0001),   0, 0, 1);
    add(1, 0, 40'h0,            0, 0, 0, 41'h0,                    0, 0, 1);
    for (int i = 0; i < 6; i++)
      add(1, 1, 40'(10 + i), 0, 1, 0, 41'h0, (i < 4) ? 3'(i + 1) : 3'd4, (i >= 4), 1);
    for (int i = 0; i < 4; i++)
      add(1, 0, 40'h0, 0, 0, 0, lnch(40'(10 + i)), 3'(3 - i), 1, 1);
    add(1, 0, 40'h0, 0, 0, 0, 41'h0, 0, 1, 1);
    add(1, 0, 40'h0, 0, 0, 1, 41'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      add(1, 1, 40'(20 + i), 0, 1, 0, 41'h0, 3'(i + 1), 0, 1);
    add(1, 1, 40'd99, 0, 1, 1, 41'h0,              4, 1, 1);
    add(1, 1, 40'd24, 0, 0, 1, lnch(40'd20),       4, 0, 1);
    add(1, 1, 40'd25, 0, 0, 0, lnch(40'd21),       4, 0, 1);
    add(1, 1, 40'd26, 0, 0, 0, lnch(40'd22),       4, 0, 1);
    for (int i = 0; i < 4; i++)
      add(1, 0, 40'h0, 0, 0, 0, lnch(40'(23 + i)), 3'(3 - i), 0, 1);
    add(1, 0, 40'h0, 0, 0, 0, 41'h0, 0, 0, 1);
    // decim=2 over samples 0..8: only 0, 3, 6 are captured
    add(1, 1, 40'd0, 2, 0, 0, 41'h0,        1, 0, 1);
    add(1, 1, 40'd1, 2, 0, 0, lnch(40'd0),  0, 0, 1);
    add(1, 1, 40'd2, 2, 0, 0, 41'h0,        0, 0, 1);
    add(1, 1, 40'd3, 2, 0, 0, 41'h0,        1, 0, 1);
    add(1, 1, 40'd4, 2, 0, 0, lnch(40'd3),  0, 0, 1);
    add(1, 1, 40'd5, 2, 0, 0, 41'h0,        0, 0, 1);
    add(1, 1, 40'd6, 2, 0, 0, 41'h0,        1, 0, 1);
    add(1, 1, 40'd7, 2, 0, 0, lnch(40'd6),  0, 0, 1);
    add(1, 1, 40'd8, 2, 0, 0, 41'h0,        0, 0, 1);
    add(1, 0, 40'd0, 0, 0, 0, 41'h0,        0, 0, 1);
    // drain to idle
    add(1, 1, 40'd30, 0, 1, 0, 41'h0,        1, 0, 1);
    add(1, 1, 40'd31, 0, 1, 0, 41'h0,        2, 0, 1);
    add(1, 1, 40'd32, 0, 1, 0, 41'h0,        3, 0, 1);
    add(0, 0, 40'd0,  0, 1, 0, 41'h0,        3, 0, 1);
    add(0, 0, 40'd0,  0, 0, 0, lnch(40'd30), 2, 0, 1);
    add(0, 0, 40'd0,  0, 0, 0, lnch(40'd31), 1, 0, 1);
    add(0, 0, 40'd0,  0, 0, 0, lnch(40'd32), 0, 0, 0);
    add(0, 1, 40'd77, 0, 0, 0, 41'h0,        0, 0, 0);
    add(0, 0, 40'd0,  0, 0, 0, 41'h0,        0, 0, 0);

    #12;
    chk("rst out", bus_m.dbgbus_out, 41'h0);
    chk("rst cnt", 41'(cnt), 41'h0);
    chk("rst ovf", 41'(ovf), 41'h0);
    chk("rst act", 41'(act), 41'h0);
    @(negedge clk);
    arst_l = 1'b1;

    foreach (tbl[i]) begin
      drive_m(tbl[i].en, tbl[i].vld, tbl[i].data, tbl[i].pb);
      decim = tbl[i].decim;
      clr   = tbl[i].clr;
      tick();
      chk($sformatf("v%0d out", i), bus_m.dbgbus_out, tbl[i].exp_out);
      chk($sformatf("v%0d cnt", i), 41'(cnt), 41'(tbl[i].exp_cnt));
      chk($sformatf("v%0d ovf", i), 41'(ovf), 41'(tbl[i].exp_ovf));
      chk($sformatf("v%0d act", i), 41'(act), 41'(tbl[i].exp_act));
    end

    // Reset pulsed mid-drain
    decim = 0; clr = 0;
    drive_m(1, 0, 40'h0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_m(1, 1, 40'(40 + i), 1);
      tick();
    end
    drive_m(0, 0, 40'h0, 1);
    tick();
    chk("drn cnt", 41'(cnt), 41'd3);
    drive_m(0, 0, 40'h0, 0);
    tick();
    chk("drn out", bus_m.dbgbus_out, lnch(40'd40));
    chk("drn cnt2", 41'(cnt), 41'd2);
    #3;
    arst_l = 1'b0;
    #1;
    chk("arst out", bus_m.dbgbus_out, 41'h0);
    chk("arst cnt", 41'(cnt), 41'h0);
    chk("arst act", 41'(act), 41'h0);
    @(negedge clk);
    arst_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post%0d out", i), bus_m.dbgbus_out, 41'h0);
      chk($sformatf("post%0d cnt", i), 41'(cnt), 41'h0);
      chk($sformatf("post%0d act", i), 41'(act), 41'h0);
    end

    // Priority segment ignores peer_busy
    en_h = 1; bus_h.peer_busy = 1;
    tick();
    chk("hip act", 41'(act_h), 41'd1);
    for (int i = 0; i < 5; i++) begin
      bus_h.dbg_vld  = (i < 3);
      bus_h.dbg_data = 40'(50 + i);
      tick();
      chk($sformatf("hip%0d out", i), bus_h.dbgbus_out,
          (i == 0 || i == 4) ? 41'h0 : lnch(40'(50 + i - 1)));
      chk($sformatf("hip%0d cnt", i), 41'(cnt_h), (i < 3) ? 41'd1 : 41'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
